rcpu_core_p: RTL and testbench

//  Parametrised multi-cycle RCPU core: fetch/decode/memory/execute FSM with a 4-entry register file and an on-chip call/data stack.

---
 rtl/rcpu_pkg.sv | 76 +++++++
 rtl/rcpu_core_p_stack.sv | 49 ++++
 rtl/rcpu_core_p.sv | 222 ++++++++++++++++++++++
 tb/tb_rcpu_core_p.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rcpu_pkg.sv
// rcpu_pkg: shared definitions for the parametrised RCPU core.
//   - opcode and ATH sub-op codes
//   - FSM state encoding
//   - sticky fault codes
//   - instruction field helpers that work on the low 13 bits of ir
package rcpu_pkg;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_LDV = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_LDM = 4'h3;
    localparam logic [3:0] OP_LDR = 4'h4;
    localparam logic [3:0] OP_LDP = 4'h5;
    localparam logic [3:0] OP_ATH = 4'h6;
    localparam logic [3:0] OP_CAL = 4'h7;
    localparam logic [3:0] OP_RET = 4'h8;
    localparam logic [3:0] OP_JLT = 4'h9;
    localparam logic [3:0] OP_PSH = 4'hA;
    localparam logic [3:0] OP_POP = 4'hB;
    localparam logic [3:0] OP_SYS = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_JRM = 4'hF;

    localparam logic [3:0] ATH_ADD = 4'h0;
    localparam logic [3:0] ATH_SUB = 4'h1;
    localparam logic [3:0] ATH_MUL = 4'h2;
    localparam logic [3:0] ATH_DIV = 4'h3;
    localparam logic [3:0] ATH_SHL = 4'h4;
    localparam logic [3:0] ATH_SHR = 4'h5;
    localparam logic [3:0] ATH_AND = 4'h6;
    localparam logic [3:0] ATH_OR  = 4'h7;
    localparam logic [3:0] ATH_XOR = 4'h8;
    localparam logic [3:0] ATH_NOT = 4'h9;
    localparam logic [3:0] ATH_INC = 4'hA;
    localparam logic [3:0] ATH_DEC = 4'hB;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UNF  = 2'b10;

    function automatic logic [3:0] f_op(input logic [12:0] lo);
        return lo[3:0];
    endfunction

    function automatic logic [1:0] f_dst(input logic [12:0] lo);
        return lo[5:4];
    endfunction

    function automatic logic [1:0] f_src(input logic [12:0] lo);
        return lo[7:6];
    endfunction

    function automatic logic [3:0] f_aop(input logic [12:0] lo);
        return lo[11:8];
    endfunction

    function automatic logic f_m(input logic [12:0] lo);
        return lo[12];
    endfunction

    // Ops that need the MEM state between DECODE and EXEC.
    function automatic logic f_is_mem(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_LDM) || (op == OP_LDR) || (op == OP_LDP);
    endfunction

endpackage

// File: rtl/rcpu_core_p_stack.sv
// rcpu_stack: synchronous call/data stack.
//   clk, resetq   clock, synchronous active-high reset (empties the stack)
//   push, wdata   write wdata on top; ignored when full
//   pop           discard top; ignored when empty
//   top           current top-of-stack entry (undefined content when empty)
//   full, empty   occupancy flags
// The core never raises push and pop in the same cycle.
module rcpu_stack #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]      cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt_m1;

    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign cnt_m1 = cnt - ONE;
    assign top    = mem[cnt_m1[AW-1:0]];

    always_ff @(posedge clk) begin
        if (resetq)
            cnt <= '0;
        else if (push && !full)
            cnt <= cnt + ONE;
        else if (pop && !empty)
            cnt <= cnt - ONE;
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!resetq && push && !full)
            mem[cnt[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rcpu_core_p.sv
// rcpu_core_p: multi-cycle RCPU core (FETCH -> DECODE -> [MEM] -> EXEC).
//   clk, resetq                 clock, synchronous active-high reset
//   mem_addr/re/we/wdata        single memory port, request held until mem_ready
//   mem_rdata, mem_ready        read data / completion, both valid in the same cycle
//   io_addr, io_wdata           reg[src] / reg[dst]
//   io_re, io_we, io_rdata      one-cycle SYS strobes in EXEC, io_rdata sampled then
//   halted, fault               sticky status (fault 01 overflow, 10 underflow)
module rcpu_core_p
    import rcpu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 16,
    parameter int RESET_PC    = 0
) (
    input  logic             clk,
    input  logic             resetq,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] io_addr,
    output logic             io_re,
    output logic             io_we,
    output logic [WIDTH-1:0] io_wdata,
    input  logic [WIDTH-1:0] io_rdata,
    output logic             halted,
    output logic [1:0]       fault
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] pc, ir, mdr;
    logic [WIDTH-1:0] regs [4];
    logic             halted_q;
    logic [1:0]       fault_q;

    // Low instruction bits; M reads as 0 when the word has no bit 12.
    logic [12:0] ir_lo;
    generate
        if (WIDTH >= 13) begin : g_lo
            assign ir_lo = ir[12:0];
        end else begin : g_lo12
            assign ir_lo = {1'b0, ir[11:0]};
        end
    endgenerate

    logic [3:0]       op, aop;
    logic [1:0]       dst, src;
    logic [WIDTH-1:0] arg, rd, rs, alu;

    assign op  = f_op(ir_lo);
    assign aop = f_aop(ir_lo);
    assign dst = f_dst(ir_lo);
    assign src = f_src(ir_lo);
    assign arg = ir >> 6;
    assign rd  = regs[dst];
    assign rs  = regs[src];

    always_comb begin
        alu = '0;
        case (aop)
            ATH_ADD: alu = rd + rs;
            ATH_SUB: alu = rd - rs;
            ATH_MUL: alu = rd * rs;
            ATH_DIV: alu = (rs == '0) ? '1 : rd / rs;
            ATH_SHL: alu = rd << rs[SHW-1:0];
            ATH_SHR: alu = rd >> rs[SHW-1:0];
            ATH_AND: alu = rd & rs;
            ATH_OR:  alu = rd | rs;
            ATH_XOR: alu = rd ^ rs;
            ATH_NOT: alu = ~rs;
            ATH_INC: alu = rd + ONE;
            ATH_DEC: alu = rd - ONE;
            default: alu = '0;
        endcase
    end

    logic [WIDTH-1:0] stk_top;
    logic             stk_full, stk_empty;

    // EXEC-cycle effects, all committed together on the EXEC edge.
    logic             wr_en, push_c, pop_c, halt_c, sys_re, sys_we;
    logic [1:0]       wr_idx, flt_c;
    logic [WIDTH-1:0] wr_val, pc_nxt, push_val;

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = dst;
        wr_val   = '0;
        pc_nxt   = pc + ONE;
        push_c   = 1'b0;
        pop_c    = 1'b0;
        push_val = rs;
        halt_c   = 1'b0;
        sys_re   = 1'b0;
        sys_we   = 1'b0;
        flt_c    = FLT_NONE;
        case (op)
            OP_MOV: begin wr_en = 1'b1; wr_val = rs; end
            OP_LDV: begin wr_en = 1'b1; wr_val = arg; end
            OP_LDA, OP_LDR: begin wr_en = 1'b1; wr_val = mdr; end
            OP_ATH: begin
                wr_en  = 1'b1;
                wr_val = alu;
                wr_idx = f_m(ir_lo) ? src : dst;
            end
            OP_CAL: begin
                if (stk_full) flt_c = FLT_OVF;
                else begin push_c = 1'b1; push_val = pc + ONE; pc_nxt = rd; end
            end
            OP_RET: begin
                if (stk_empty) flt_c = FLT_UNF;
                else begin pop_c = 1'b1; pc_nxt = stk_top; end
            end
            OP_JLT: if (regs[0] < rd) pc_nxt = rs;
            OP_PSH: begin
                if (stk_full) flt_c = FLT_OVF;
                else push_c = 1'b1;
            end
            OP_POP: begin
                if (stk_empty) flt_c = FLT_UNF;
                else begin pop_c = 1'b1; wr_en = 1'b1; wr_val = stk_top; end
            end
            // ir[6] is also src[0]: odd src selects the write form.
            OP_SYS: begin
                if (ir_lo[6]) sys_we = 1'b1;
                else begin sys_re = 1'b1; wr_en = 1'b1; wr_val = io_rdata; end
            end
            OP_HLT: halt_c = 1'b1;
            OP_JMP: pc_nxt = arg;
            OP_JRM: pc_nxt = rs;
            default: ;
        endcase
    end

    logic in_exec;
    assign in_exec = (state == S_EXEC) && !resetq;

    rcpu_stack #(.DEPTH(STACK_DEPTH), .WIDTH(WIDTH)) u_stack (
        .clk   (clk),
        .resetq(resetq),
        .push  (in_exec && push_c),
        .pop   (in_exec && pop_c),
        .wdata (push_val),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (resetq) begin
            state    <= S_FETCH;
            pc       <= WIDTH'(RESET_PC);
            ir       <= '0;
            mdr      <= '0;
            halted_q <= 1'b0;
            fault_q  <= FLT_NONE;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir    <= mem_rdata;
                    state <= S_DECODE;
                end
                S_DECODE: state <= f_is_mem(op) ? S_MEM : S_EXEC;
                S_MEM: if (mem_ready) begin
                    if (op == OP_LDA || op == OP_LDR) mdr <= mem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (flt_c != FLT_NONE) begin
                        fault_q <= flt_c;
                        state   <= S_FAULT;
                    end else if (halt_c) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        if (wr_en) regs[wr_idx] <= wr_val;
                        pc    <= pc_nxt;
                        state <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state and are forced low during reset,
    // so a pending request drops in the very cycle reset is raised.
    logic mem_rd_op, mem_wr_op;
    assign mem_rd_op = (op == OP_LDA) || (op == OP_LDR);
    assign mem_wr_op = (op == OP_LDM) || (op == OP_LDP);

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!resetq) begin
            if (state == S_FETCH) begin
                mem_re   = 1'b1;
                mem_addr = pc;
            end else if (state == S_MEM) begin
                mem_re    = mem_rd_op;
                mem_we    = mem_wr_op;
                mem_addr  = (op == OP_LDR) ? rs : (op == OP_LDP) ? rd : arg;
                mem_wdata = (op == OP_LDM) ? rd : (op == OP_LDP) ? rs : '0;
            end
        end
    end

    assign io_re    = in_exec && (op == OP_SYS) && sys_re;
    assign io_we    = in_exec && (op == OP_SYS) && sys_we;
    assign io_addr  = resetq ? '0 : rs;
    assign io_wdata = resetq ? '0 : rd;
    assign halted   = halted_q && !resetq;
    assign fault    = resetq ? FLT_NONE : fault_q;

endmodule

// File: tb/tb_rcpu_core_p.sv
module tb_rcpu_core_p;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         resetq = 1'b1;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata, io_addr, io_wdata;
    logic [W-1:0] io_rdata = 24'h00005C;
    logic         mem_re, mem_we, mem_ready, io_re, io_we, halted;
    logic [1:0]   fault;

    rcpu_core_p #(.WIDTH(W), .STACK_DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .resetq(resetq),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .io_addr(io_addr), .io_re(io_re), .io_we(io_we),
        .io_wdata(io_wdata), .io_rdata(io_rdata),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Memory model: ready comes after 'lat' wait cycles of a held request.
    logic [W-1:0] mem [0:255];
    int  lat = 0, wcnt = 0;
    logic clr = 1'b1;
    int  we_cyc, wr_cnt, io_we_cnt, io_re_cnt;
    logic [W-1:0] last_rd, io_we_data, io_we_addr;

    assign mem_ready = (mem_re || mem_we) && (wcnt == lat);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (resetq || !(mem_re || mem_we) || mem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (clr) begin
            we_cyc <= 0; wr_cnt <= 0; io_we_cnt <= 0; io_re_cnt <= 0;
            last_rd <= '0; io_we_data <= '0; io_we_addr <= '0;
        end else begin
            if (mem_we) we_cyc <= we_cyc + 1;
            if (mem_we && mem_ready) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_re && mem_ready) last_rd <= mem_addr;
            if (io_we) begin
                io_we_cnt <= io_we_cnt + 1;
                io_we_data <= io_wdata;
                io_we_addr <= io_addr;
            end
            if (io_re) io_re_cnt <= io_re_cnt + 1;
        end
    end

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ins(input int op, input int d, input int s,
                                         input int aop = 0, input int m = 0);
        return W'(op | (d << 4) | (s << 6) | (aop << 8) | (m << 12));
    endfunction

    function automatic logic [W-1:0] ldv(input int d, input int a);
        return W'(1 | (d << 4) | (a << 6));
    endfunction

    function automatic logic [W-1:0] ldm(input int d, input int a);
        return W'(3 | (d << 4) | (a << 6));
    endfunction

    function automatic logic [W-1:0] lda(input int d, input int a);
        return W'(2 | (d << 4) | (a << 6));
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Reset, release, then run until halted or faulted; returns cycles used.
    task automatic run(input int l, input int budget, output int cyc);
        bit done;
        lat = l;
        @(negedge clk);
        resetq = 1'b1;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        resetq = 1'b0;
        cyc = 0;
        done = 0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (halted || fault != 2'b00) done = 1;
        end
        if (!done) chk("timeout", 32'(cyc), 32'(budget + 1));
    endtask

    int cyc;

    initial begin
        // T1: add program, zero-wait memory, CPI 3
        clear_mem();
        mem[0] = ldv(1, 5);
        mem[1] = ldv(2, 7);
        mem[2] = ins(6, 1, 2, 0);
        mem[3] = ins(13, 1, 2);
        #1;
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_fault", 32'(fault), 0);
        run(0, 200, cyc);
        chk("t1_cycles", 32'(cyc), 12);
        chk("t1_halted", 32'(halted), 1);
        chk("t1_r1", 32'(io_wdata), 12);
        chk("t1_r2", 32'(io_addr), 7);
        @(posedge clk); #1;
        chk("t1_no_req", 32'(mem_re | mem_we), 0);
        @(negedge clk);
        resetq = 1'b1;
        #1;
        chk("t1_rst_halted", 32'(halted), 0);

        // T2: store then load with two wait cycles per access
        clear_mem();
        mem[0] = ldv(1, 8'h5A);
        mem[1] = ldm(1, 8'h20);
        mem[2] = lda(3, 8'h20);
        mem[3] = ins(13, 3, 1);
        run(2, 400, cyc);
        chk("t2_cycles", 32'(cyc), 26);
        chk("t2_we_cycles", 32'(we_cyc), 3);
        chk("t2_writes", 32'(wr_cnt), 1);
        chk("t2_mem20", 32'(mem[8'h20]), 32'h5A);
        chk("t2_lda", 32'(io_wdata), 32'h5A);

        // T3: CAL/RET returns to caller+1
        clear_mem();
        mem[0] = ldv(1, 8'h10);
        mem[1] = ins(7, 1, 0);
        mem[2] = ins(13, 2, 0);
        mem[8'h10] = ldv(2, 8'h33);
        mem[8'h11] = ins(8, 0, 0);
        run(0, 300, cyc);
        chk("t3_halted", 32'(halted), 1);
        chk("t3_fault", 32'(fault), 0);
        chk("t3_r2", 32'(io_wdata), 32'h33);
        chk("t3_ret_pc", 32'(last_rd), 2);
        // A second RET right after return proves the stack was left empty.
        mem[2] = ins(8, 0, 0);
        run(0, 300, cyc);
        chk("t3_empty", 32'(fault), 2);
        chk("t3_not_halt", 32'(halted), 0);

        // T4: LIFO order, overflow on fifth push, underflow on empty pop
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            mem[2*i]   = ldv(1, i + 1);
            mem[2*i+1] = ins(10, 0, 1);
        end
        mem[8]  = ins(11, 2, 0);
        mem[9]  = ins(11, 3, 0);
        mem[10] = ins(13, 2, 3);
        run(0, 300, cyc);
        chk("t4_pop1", 32'(io_wdata), 4);
        chk("t4_pop2", 32'(io_addr), 3);
        chk("t4_fault0", 32'(fault), 0);
        clear_mem();
        mem[0] = ldv(1, 9);
        for (int i = 1; i <= 5; i++) mem[i] = ins(10, 0, 1);
        mem[6] = ins(13, 0, 0);
        run(0, 300, cyc);
        chk("t4_ovf", 32'(fault), 1);
        chk("t4_ovf_pc", 32'(last_rd), 5);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_ovf_stuck", 32'(mem_re), 0);
        clear_mem();
        mem[0] = ins(11, 1, 0);
        run(0, 100, cyc);
        chk("t4_unf", 32'(fault), 2);

        // T5: 24-bit ALU corners
        clear_mem();
        mem[0]  = ldv(1, 5);
        mem[1]  = ldv(2, 0);
        mem[2]  = ins(6, 1, 2, 3);
        mem[3]  = ldm(1, 8'h30);
        mem[4]  = ldv(3, 1);
        mem[5]  = ldv(0, 23);
        mem[6]  = ins(6, 3, 0, 4);
        mem[7]  = ins(6, 1, 0, 10);
        mem[8]  = ldm(1, 8'h31);
        mem[9]  = ldv(2, 10);
        mem[10] = ins(6, 1, 2, 1, 1);
        mem[11] = ins(13, 3, 2);
        mem[8'h31] = 24'h000123;
        run(0, 400, cyc);
        chk("t5_div0", 32'(mem[8'h30]), 32'hFFFFFF);
        chk("t5_inc_wrap", 32'(mem[8'h31]), 0);
        chk("t5_shl", 32'(io_wdata), 32'h800000);
        chk("t5_sub_m", 32'(io_addr), 32'hFFFFF6);

        // T6: SYS write then SYS read
        clear_mem();
        mem[0] = ldv(3, 8'hAB);
        mem[1] = ldv(1, 4);
        mem[2] = ins(12, 3, 1);
        mem[3] = ldv(2, 9);
        mem[4] = ins(12, 0, 2);
        mem[5] = ins(13, 0, 2);
        run(0, 300, cyc);
        chk("t6_we_cnt", 32'(io_we_cnt), 1);
        chk("t6_wdata", 32'(io_we_data), 32'hAB);
        chk("t6_waddr", 32'(io_we_addr), 4);
        chk("t6_re_cnt", 32'(io_re_cnt), 1);
        chk("t6_rdata", 32'(io_wdata), 32'h5C);

        // T7: reset raised during a FETCH wait drops the request
        clear_mem();
        lat = 5;
        @(negedge clk);
        resetq = 1'b1;
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        resetq = 1'b0;
        @(posedge clk); #1;
        chk("t7_waiting", 32'(mem_re), 1);
        @(negedge clk);
        resetq = 1'b1;
        #1;
        chk("t7_drop_now", 32'(mem_re), 0);
        @(posedge clk); #1;
        chk("t7_drop_next", 32'(mem_re | mem_we), 0);
        chk("t7_no_write", 32'(wr_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
